// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// A radix-2 shift-add multiplier and a restoring divider share one 2*XLEN
// accumulator and one FSM. Operands are converted to magnitudes on accept;
// the sign is reapplied to the final value on the edge that enters DONE.
//
// Handshake: start is sampled only in IDLE (and only when kill is low).
// busy is high in CALC and DONE. done is a one-cycle pulse in DONE, during
// which result/rd_out are valid. wb_en = done && rd_out != 0. kill in CALC
// or DONE returns the unit to IDLE on the next edge without a done pulse.
// Every output comes from a register.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wb_en
);

    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mcand;    // multiplicand or divisor magnitude
    logic [4:0]        r_rd_pend;  // rd of the operation in flight
    logic              r_busy;
    logic              r_done;
    logic              r_wb_en;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    // ---------------- accept-time decode ----------------
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_neg;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;

    assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg    = w_a_signed & rs1_val[XLEN-1];
    assign w_b_neg    = w_b_signed & rs2_val[XLEN-1];
    assign w_a_mag    = w_a_neg ? -rs1_val : rs1_val;
    assign w_b_mag    = w_b_neg ? -rs2_val : rs2_val;
    // Remainder takes the dividend's sign; everything else takes sign(A)^sign(B).
    assign w_neg      = (op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // Divide-by-zero and signed overflow finish in one cycle with fixed values.
    assign w_div0 = op[2] && (rs2_val == ZERO);
    assign w_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (rs1_val == MIN_INT) && (rs2_val == ALL_ONES);
    assign w_special = w_div0 | w_ovf;
    assign w_special_val = w_div0 ? (op[1] ? rs1_val : ALL_ONES)
                                  : (op[1] ? ZERO : MIN_INT);

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_step;

    // Multiply: add multiplicand to the upper half when the multiplier LSB
    // is set, then shift the whole accumulator (with carry) right by one.
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_mcand} : {1'b0, ZERO});
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Divide: shift {rem, dividend} left, trial-subtract the divisor from the
    // XLEN+1-bit partial remainder, keep it when non-negative.
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_rem_sh - {1'b0, r_mcand};
    assign w_ge       = ~w_diff[XLEN];
    assign w_div_next = {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_ge};

    assign w_step = r_op[2] ? w_div_next : w_mul_next;

    // ---------------- final value (used on the last CALC edge) ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_final;
    logic [XLEN-1:0]   w_div_res;
    logic [XLEN-1:0]   w_div_final;
    logic [XLEN-1:0]   w_final;

    assign w_prod      = r_neg ? -w_mul_next : w_mul_next;
    assign w_mul_final = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign w_div_res   = r_op[1] ? w_div_next[2*XLEN-1:XLEN] : w_div_next[XLEN-1:0];
    assign w_div_final = r_neg ? -w_div_res : w_div_res;
    assign w_final     = r_op[2] ? w_div_final : w_mul_final;

    // Control FSM with registered outputs; also owns the datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_rd_pend <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wb_en   <= 1'b0;
            r_result  <= '0;
            r_rd_out  <= 5'd0;
        end else begin
            r_done  <= 1'b0;
            r_wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !kill) begin
                        r_op      <= op;
                        r_neg     <= w_neg;
                        r_cnt     <= '0;
                        r_rd_pend <= rd_in;
                        r_busy    <= 1'b1;
                        if (w_special) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_wb_en  <= (rd_in != 5'd0);
                            r_result <= w_special_val;
                            r_rd_out <= rd_in;
                        end else begin
                            r_state <= S_CALC;
                            r_acc   <= op[2] ? {ZERO, w_a_mag} : {ZERO, w_b_mag};
                            r_mcand <= op[2] ? w_b_mag : w_a_mag;
                        end
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_step;
                        if (r_cnt == LAST_CNT) begin
                            r_state  <= S_DONE;
                            r_cnt    <= '0;
                            r_done   <= 1'b1;
                            r_wb_en  <= (r_rd_pend != 5'd0);
                            r_result <= w_final;
                            r_rd_out <= r_rd_pend;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign wb_en  = r_wb_en;
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of hand-computed vectors plus
// hand-written sequences for kill, async reset, and start-while-busy cases.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int NV   = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            wb_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[NV];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .kill    (kill),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .wb_en   (wb_en)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one request; returns #1 after the accepting edge with start low.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges (starting from init) until done is seen, bounded.
  task automatic wait_done(input int init, output int lat);
    lat = init;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] prev;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         33};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd1,  32'h00000000,   33};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd2,  32'hFFFFFFFE,   33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd3,  32'hFFFFFFFF,   33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFD,   33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFF,   33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          5'd7,  32'd14,         33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          5'd8,  32'd2,          33};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,          5'd9,  32'hFFFFFFFF,   1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,          5'd10, 32'd5,          1};
    vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'h80000000,   1};
    vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF,   5'd12, 32'h00000000,   1};
    vecs[12] = '{3'd5, 32'd5,          32'd0,          5'd13, 32'hFFFFFFFF,   1};
    vecs[13] = '{3'd7, 32'd5,          32'd0,          5'd14, 32'd5,          1};
    vecs[14] = '{3'd0, 32'hFFFFFFFD,   32'd5,          5'd15, 32'hFFFFFFF1,   33};
    vecs[15] = '{3'd1, 32'hFFFFFFFD,   32'd5,          5'd16, 32'hFFFFFFFF,   33};
    vecs[16] = '{3'd4, 32'd7,          32'hFFFFFFFE,   5'd17, 32'hFFFFFFFD,   33};
    vecs[17] = '{3'd6, 32'd7,          32'hFFFFFFFE,   5'd18, 32'd1,          33};
    vecs[18] = '{3'd5, 32'h80000000,   32'hFFFFFFFF,   5'd19, 32'h00000000,   33};
    vecs[19] = '{3'd7, 32'h80000000,   32'hFFFFFFFF,   5'd0,  32'h80000000,   33};

    // reset
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0;
    rs1_val = '0; rs2_val = '0; rd_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'd0, busy},  32'd0);
    chk("reset_done",   {31'd0, done},  32'd0);
    chk("reset_wb_en",  {31'd0, wb_en}, 32'd0);
    chk("reset_result", result,         32'd0);
    chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // table vectors
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_done(1, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp);
      chk($sformatf("v%0d_rd_out", i), {27'd0, rd_out}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_wb_en", i), {31'd0, wb_en}, {31'd0, (vecs[i].rd != 5'd0)});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_after", i), {30'd0, busy, done}, 32'd0);
    end
    prev = vecs[NV-1].exp;

    // kill at CALC cycle 10
    issue(3'd0, 32'd9, 32'd9, 5'd20);
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || wb_en) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("kill_no_done", seen, 0);
    chk("kill_result_kept", result, prev);
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    wait_done(1, lat);
    chk("after_kill_latency", lat, 33);
    chk("after_kill_result", result, 32'd14);
    @(posedge clk);
    #1;

    // start while busy is ignored; rd=0 gives done without wb_en
    issue(3'd0, 32'd3, 32'd3, 5'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 3'd3; rs1_val = 32'hFFFFFFFF; rs2_val = 32'hFFFFFFFF; rd_in = 5'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, lat);
    chk("busy_start_latency", lat, 33);
    chk("busy_start_result", result, 32'd9);
    chk("busy_start_done", {31'd0, done}, 32'd1);
    chk("busy_start_wb_en", {31'd0, wb_en}, 32'd0);
    chk("busy_start_rd_out", {27'd0, rd_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_start_no_queue", {31'd0, busy}, 32'd0);

    // start in the same cycle as done: ignored, accepted in IDLE next cycle
    issue(3'd0, 32'd2, 32'd3, 5'd4);
    wait_done(1, lat);
    chk("done_start_first", result, 32'd6);
    @(negedge clk);
    op = 3'd0; rs1_val = 32'd4; rs2_val = 32'd5; rd_in = 5'd6; start = 1'b1;
    @(posedge clk);
    #1;
    chk("done_start_ignored", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_start_accepted", {31'd0, busy}, 32'd1);
    wait_done(1, lat);
    chk("done_start_latency", lat, 33);
    chk("done_start_result", result, 32'd20);
    chk("done_start_rd_out", {27'd0, rd_out}, 32'd6);
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of CALC
    issue(3'd0, 32'd7, 32'd7, 5'd9);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_busy",   {31'd0, busy},   32'd0);
    chk("areset_done",   {31'd0, done},   32'd0);
    chk("areset_result", result,          32'd0);
    chk("areset_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // kill together with start in IDLE: start ignored
    op = 3'd0; rs1_val = 32'd5; rs2_val = 32'd5; rd_in = 5'd1; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    chk("kill_start_idle", {31'd0, busy}, 32'd0);

    // unit still works after reset
    issue(3'd0, 32'd3, 32'd3, 5'd0);
    wait_done(1, lat);
    chk("post_reset_latency", lat, 33);
    chk("post_reset_result", result, 32'd9);
    chk("post_reset_wb_en", {31'd0, wb_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
